// File: rtl/uart_tx_core.sv
// Purpose : UART transmitter; serializes a parallel word LSB-first as start/data/[parity]/stop.
// Latency : start bit on TX_OUT the cycle after the accepting edge; one CLK cycle per bit.
// Backpr. : no queueing; DATA_VALID is honoured only in IDLE or the last stop cycle, so upstream holds until busy=0.
//
// Ports:
//   CLK        - TX clock, already divided to the baud rate (one cycle = one bit time)
//   RESET      - asynchronous, active-high; aborts any frame and returns the line high
//   P_DATA     - word to send, latched on acceptance
//   DATA_VALID - send request
//   PAR_EN     - insert a parity bit (latched on acceptance)
//   PAR_TYP    - 0 = even, 1 = odd parity (latched on acceptance)
//   TX_OUT     - registered serial line, idles high
//   busy       - registered, high while a frame is in flight
//
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (acceptance moves to the second one).
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                nxt_state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit;
    logic                  par_en_q;
    logic                  nxt_tx;
    logic                  accept;
    logic                  stop_last;

`ifdef UART_TX_TWO_STOP_EN
    // Set during the second stop cycle; only then may a new frame be accepted.
    logic stop_cnt;
    assign stop_last = stop_cnt;
`else
    assign stop_last = 1'b1;
`endif

    always_comb begin
        nxt_state = IDLE;
        nxt_tx    = 1'b1;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    accept    = 1'b1;
                    nxt_state = START;
                end else begin
                    nxt_state = IDLE;
                end
            end
            START:  nxt_state = DATA;
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    nxt_state = par_en_q ? PARITY : STOP;
                end else begin
                    nxt_state = DATA;
                end
            end
            PARITY: nxt_state = STOP;
            STOP: begin
                if (!stop_last) begin
                    nxt_state = STOP;
                end else if (DATA_VALID) begin
                    // back-to-back frame: start bit directly follows the stop bit
                    accept    = 1'b1;
                    nxt_state = START;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        // The line is registered from the state being entered, so each bit
        // appears exactly in the cycle its state is occupied.
        case (nxt_state)
            START:   nxt_tx = 1'b0;
            DATA:    nxt_tx = shift[0];
            PARITY:  nxt_tx = par_bit;
            default: nxt_tx = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= 1'b0;
`endif
        end else begin
            state  <= nxt_state;
            TX_OUT <= nxt_tx;
            busy   <= (nxt_state != IDLE);

            if (accept) begin
                shift    <= P_DATA;
                par_en_q <= PAR_EN;
                par_bit  <= (^P_DATA) ^ PAR_TYP;
            end else if (nxt_state == DATA) begin
                // bit 0 goes to the line on this edge; expose the next one
                shift <= shift >> 1;
            end

            if (nxt_state == DATA) begin
                bit_cnt <= (state == DATA) ? bit_cnt + CNT_W'(1) : '0;
            end

`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= (state == STOP) && !stop_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    always #5 CLK = ~CLK;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    // One record per clock: inputs presented before the edge, outputs expected after it.
    typedef struct {
        string      name;
        logic       dv;
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       tx;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic tx_e, input logic busy_e);
        n_vec++;
        if (TX_OUT !== tx_e || busy !== busy_e) begin
            n_err++;
            $display("FAIL %s @%0t: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
                     name, $time, TX_OUT, busy, tx_e, busy_e);
        end
    endtask

    // Appends one vector per character of 'bits' ('0'/'1' = expected TX_OUT).
    task automatic add_seq(input string name, input logic dv, input logic [7:0] d,
                           input logic pe, input logic pt, input string bits, input logic b);
        vec_t v;
        for (int i = 0; i < bits.len(); i++) begin
            v.name = name;
            v.dv   = dv;
            v.data = d;
            v.pe   = pe;
            v.pt   = pt;
            v.tx   = (bits.getc(i) == "1");
            v.busy = b;
            tbl.push_back(v);
        end
    endtask

    // Additional stop cycles of the two-stop build, inserted right after the first stop bit.
    task automatic add_extra_stops(input string name, input logic dv, input logic [7:0] d,
                                   input logic pe, input logic pt);
        for (int i = 1; i < NSTOP; i++) add_seq(name, dv, d, pe, pt, "1", 1'b1);
    endtask

    task automatic apply(input vec_t v);
        DATA_VALID = v.dv;
        P_DATA     = v.data;
        PAR_EN     = v.pe;
        PAR_TYP    = v.pt;
        @(posedge CLK);
        @(negedge CLK);
        check(v.name, v.tx, v.busy);
    endtask

    initial begin
        RESET      = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Test 1: reset state, then idle line for 20 cycles with no request.
        @(negedge CLK);
        check("reset state", 1'b1, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("t1 idle", 1'b1, 1'b0);
        end

        // Test 2: 0xA5 even parity -> 0,10100101,0,1 ; busy for 11 cycles.
        add_seq("t2 start", 1'b1, 8'hA5, 1'b1, 1'b0, "0", 1'b1);
        add_seq("t2 frame", 1'b0, 8'hA5, 1'b1, 1'b0, "1010010101", 1'b1);
        add_extra_stops("t2 stop2", 1'b0, 8'hA5, 1'b1, 1'b0);
        add_seq("t2 idle", 1'b0, 8'hA5, 1'b1, 1'b0, "11", 1'b0);

        // Test 3a: 0xA5 odd parity -> parity bit 1.
        add_seq("t3 odd start", 1'b1, 8'hA5, 1'b1, 1'b1, "0", 1'b1);
        add_seq("t3 odd frame", 1'b0, 8'hA5, 1'b1, 1'b1, "1010010111", 1'b1);
        add_extra_stops("t3 odd stop2", 1'b0, 8'hA5, 1'b1, 1'b1);
        add_seq("t3 odd idle", 1'b0, 8'hA5, 1'b1, 1'b1, "1", 1'b0);

        // Test 3b: 0xA5 without parity -> 10-cycle frame.
        add_seq("t3 nopar start", 1'b1, 8'hA5, 1'b0, 1'b0, "0", 1'b1);
        add_seq("t3 nopar frame", 1'b0, 8'hA5, 1'b0, 1'b0, "101001011", 1'b1);
        add_extra_stops("t3 nopar stop2", 1'b0, 8'hA5, 1'b0, 1'b0);
        add_seq("t3 nopar idle", 1'b0, 8'hA5, 1'b0, 1'b0, "1", 1'b0);

        // Test 4: DATA_VALID held; 0x3C odd (parity 1), then 0xFF back-to-back (parity 1).
        add_seq("t4 frame1", 1'b1, 8'h3C, 1'b1, 1'b1, "00011110011", 1'b1);
        add_extra_stops("t4 stop2", 1'b1, 8'h3C, 1'b1, 1'b1);
        add_seq("t4 b2b start", 1'b1, 8'hFF, 1'b1, 1'b1, "0", 1'b1);
        add_seq("t4 frame2", 1'b0, 8'hFF, 1'b1, 1'b1, "1111111111", 1'b1);
        add_extra_stops("t4 frame2 stop2", 1'b0, 8'hFF, 1'b1, 1'b1);
        add_seq("t4 idle", 1'b0, 8'hFF, 1'b1, 1'b1, "1", 1'b0);

        // Test 5: 0x0F even parity; mid-frame input changes and requests must be ignored.
        add_seq("t5 start", 1'b1, 8'h0F, 1'b1, 1'b0, "0", 1'b1);
        add_seq("t5 req in start", 1'b1, 8'hF0, 1'b1, 1'b1, "1", 1'b1);
        add_seq("t5 frame", 1'b0, 8'h0F, 1'b1, 1'b0, "11", 1'b1);
        add_seq("t5 req in data", 1'b1, 8'hF0, 1'b1, 1'b1, "1", 1'b1);
        add_seq("t5 frame", 1'b0, 8'h0F, 1'b1, 1'b0, "0000", 1'b1);
        add_seq("t5 req before parity", 1'b1, 8'hF0, 1'b0, 1'b1, "0", 1'b1);
        add_seq("t5 stop", 1'b0, 8'h0F, 1'b1, 1'b0, "1", 1'b1);
        add_extra_stops("t5 stop2", 1'b0, 8'h0F, 1'b1, 1'b0);
        add_seq("t5 idle", 1'b0, 8'h0F, 1'b1, 1'b0, "111", 1'b0);

        foreach (tbl[i]) apply(tbl[i]);

        // Test 6: reset asserted while data bit 4 (a 0) of 0xA5 is on the line.
        tbl.delete();
        add_seq("t6 start", 1'b1, 8'hA5, 1'b0, 1'b0, "0", 1'b1);
        add_seq("t6 bits0-4", 1'b0, 8'hA5, 1'b0, 1'b0, "10100", 1'b1);
        foreach (tbl[i]) apply(tbl[i]);

        #2 RESET = 1'b1;
        #1 check("t6 async reset", 1'b1, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check("t6 reset held", 1'b1, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("t6 idle after reset", 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
